fc4_argmax_unit: RTL and testbench
==================================

Name: fc4_argmax_unit

Overview:
Final classification stage downstream of the 64-entry ReLU3 activation memory. On a start pulse it reads the 64 signed activations through the memory's address/data read port and computes NUM_OUT dot products against a weight memory, plus a per-neuron bias. Each logit is written to a logit memory as it is produced, and a running argmax yields the predicted class. A done pulse hands the result to the display/top-level controller.

Parameters:
NUM_IN, 64, activations per input vector (depth of ReLU3 memory)
NUM_OUT, 10, output neurons/classes
DATA_W, 32, signed fixed-point width of activations, weights, biases, logits
FRAC_BITS, 16, fractional bits (Q16.16)
ACC_W, 72, signed accumulator width (2*DATA_W + clog2(NUM_IN) + margin)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start request; honoured only in IDLE
busy  out  1  high from first MAC cycle until done
done  out  1  one-cycle pulse when all logits are written
act_addr  out  16  read address into ReLU3 memory
act_data  in  32  signed activation; combinational read, valid same cycle as act_addr
w_addr  out  16  weight address = neuron*NUM_IN + i
w_data  in  32  signed weight; combinational read
b_addr  out  16  bias address = neuron index
b_data  in  32  signed bias; combinational read
logit_we  out  1  write enable to logit memory
logit_addr  out  16  neuron index for logit write
logit_data  out  32  signed saturated logit
pred_class  out  4  argmax index; held until next done
max_logit  out  32  logit value at pred_class

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, logit_we=0, all addresses=0, logit_data=0, pred_class=0, max_logit=0x80000000; accumulator, counters cleared. Reset mid-run abandons the computation; no further logit writes.
- States: IDLE, MAC, WRITE, DONE.
- IDLE: start=1 at edge -> MAC; neuron=0, i=0, acc=0, running max=most-negative, running idx=0. pred_class/max_logit keep previous values until DONE.
- MAC (NUM_IN cycles per neuron): act_addr=i, w_addr=neuron*NUM_IN+i; each edge acc += sign-extended (act_data*w_data) (full 64-bit product); i increments; after i=NUM_IN-1 -> WRITE.
- WRITE (1 cycle): b_addr=neuron; sum = (acc >>> FRAC_BITS) + sign-extended b_data; logit = saturate sum to [0x80000000, 0x7FFFFFFF]. logit_we=1, logit_addr=neuron, logit_data=logit (registered outputs, valid this cycle). If logit > running max (strict, so ties keep the lower index), or neuron=0: update max/idx. If neuron=NUM_OUT-1 -> DONE; else neuron++, i=0, acc=0 -> MAC.
- DONE (1 cycle): done=1, busy=0, pred_class/max_logit load running idx/max; -> IDLE.
- Latency: done is high exactly NUM_OUT*(NUM_IN+1)+1 cycles after the start edge (651 with defaults). busy is high for NUM_OUT*(NUM_IN+1) cycles.
- start during MAC/WRITE/DONE is ignored and does not queue. start in the same cycle as DONE is ignored; start on the cycle after done begins a new run.
- Arithmetic: signed throughout; arithmetic right shift (floor toward -inf); no rounding. Addresses outside NUM_IN/NUM_OUT are never driven.

Decomposition:
- Shared package nn_pkg: DATA_W, FRAC_BITS, NUM_IN/NUM_OUT constants, the saturate-to-DATA_W function, and the state enum encoding.
- One sub-module: fc_mac (signed multiply-accumulate with clear, enable, and ACC_W accumulator), reusable by the earlier matmul stages.

Test Plan:
- act[i]=0x00010000 for all i; weight of neuron k = k*0x00000400 for all i; bias=0 -> logits k<<16 written at addr 0..9, pred_class=9, max_logit=0x00090000, done exactly 651 cycles after start.
- All activations 0; bias = {5,3,9,9,1,0,0,0,0,0}<<16 -> logits equal the biases; pred_class=2 (tie with index 3 keeps the lower index); max_logit=0x00090000.
- All act=0x7FFF0000 and all w=0x7FFF0000 -> every logit_data=0x7FFFFFFF (saturated); with w negated -> 0x80000000; pred_class=0.
- Negative logits: all weights -0x00010000, act=0x00010000, bias k=-k<<16 -> logit k = -(64+k)<<16; pred_class=0.
- Pulse start repeatedly at cycles 5, 100, 650 of a run -> exactly 10 logit_we pulses and one done; no restart.
- Assert rst_n=0 at cycle 300 -> outputs return to reset values immediately; no logit_we after reset; a new start produces a correct full run.

Source files
------------

// File: rtl/fc4_argmax_unit_pkg.sv
// -----------------------------------------------------------------------------
// fc4_argmax_unit_pkg
// Shared constants, FSM state encoding and the saturation helper for the final
// fully-connected classification stage and its multiply-accumulate core.
// No ports: this is a package imported by the interface, top and sub-module.
// -----------------------------------------------------------------------------
package fc4_argmax_unit_pkg;

    localparam int NUM_IN    = 64;   // activations per input vector
    localparam int NUM_OUT   = 10;   // output neurons / classes
    localparam int DATA_W    = 32;   // Q16.16 signed data width
    localparam int FRAC_BITS = 16;   // fractional bits
    localparam int ACC_W     = 72;   // signed accumulator width
    localparam int ADDR_W    = 16;   // width of every memory address port
    localparam int IDX_W     = $clog2(NUM_IN);
    localparam int CLASS_W   = $clog2(NUM_OUT);

    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clamp a wide signed value into DATA_W. The value fits exactly when all
    // bits from the DATA_W sign bit upwards agree; otherwise the sign of the
    // wide value selects the rail.
    function automatic logic signed [DATA_W-1:0] sat_data(
        input logic signed [ACC_W-1:0] v
    );
        logic [ACC_W-DATA_W:0] upper;
        upper = v[ACC_W-1:DATA_W-1];
        if ((&upper) || (~|upper)) begin
            sat_data = v[DATA_W-1:0];
        end else if (v[ACC_W-1]) begin
            sat_data = DATA_MIN;
        end else begin
            sat_data = DATA_MAX;
        end
    endfunction

endpackage

// File: rtl/fc4_argmax_unit_if.sv
// -----------------------------------------------------------------------------
// fc4_argmax_unit_if
// Bundles the control handshake, the three combinational read ports
// (activation, weight, bias), the logit write port and the classification
// result of the FC4/argmax stage.
//   master : the classification unit (drives addresses, busy/done, logits,
//            result; receives start and read data)
//   slave  : the surrounding controller and memories
// Signals:
//   start, busy, done                       control handshake
//   act_addr/act_data                       ReLU3 activation read port
//   w_addr/w_data, b_addr/b_data            weight and bias read ports
//   logit_we/logit_addr/logit_data          logit memory write port
//   pred_class, max_logit                   argmax result, held until next done
// -----------------------------------------------------------------------------
interface fc4_argmax_unit_if;
    import fc4_argmax_unit_pkg::*;

    logic                      start;
    logic                      busy;
    logic                      done;
    logic [ADDR_W-1:0]         act_addr;
    logic signed [DATA_W-1:0]  act_data;
    logic [ADDR_W-1:0]         w_addr;
    logic signed [DATA_W-1:0]  w_data;
    logic [ADDR_W-1:0]         b_addr;
    logic signed [DATA_W-1:0]  b_data;
    logic                      logit_we;
    logic [ADDR_W-1:0]         logit_addr;
    logic signed [DATA_W-1:0]  logit_data;
    logic [CLASS_W-1:0]        pred_class;
    logic signed [DATA_W-1:0]  max_logit;

    modport master (
        input  start, act_data, w_data, b_data,
        output busy, done, act_addr, w_addr, b_addr,
               logit_we, logit_addr, logit_data, pred_class, max_logit
    );

    modport slave (
        output start, act_data, w_data, b_data,
        input  busy, done, act_addr, w_addr, b_addr,
               logit_we, logit_addr, logit_data, pred_class, max_logit
    );

endinterface

// File: rtl/fc4_argmax_unit_fc_mac.sv
// -----------------------------------------------------------------------------
// fc_mac
// Signed multiply-accumulate with synchronous clear and enable. The full
// 2*DATA_W product is sign-extended into an ACC_W accumulator.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears accumulator)
//   clr_i        clear accumulator at the next edge (wins over en_i)
//   en_i         add a_i*b_i into the accumulator at the next edge
//   a_i, b_i     signed operands
//   acc_nxt_o    accumulator plus current product; this is the value the
//                accumulator takes at the next enabled edge, so a consumer
//                can capture a finished sum in the same cycle as the last
//                accumulation
// -----------------------------------------------------------------------------
module fc_mac #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 72
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_nxt_o
);

    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    // Operands widened first so the product is a full-width signed result.
    assign a_ext    = {{DATA_W{a_i[DATA_W-1]}}, a_i};
    assign b_ext    = {{DATA_W{b_i[DATA_W-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign acc_d    = acc_q + prod_ext;

    assign acc_nxt_o = acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/fc4_argmax_unit.sv
// -----------------------------------------------------------------------------
// fc4_argmax_unit
// Final classification layer: for each of NUM_OUT neurons, accumulates NUM_IN
// activation*weight products, adds the neuron bias after dropping FRAC_BITS,
// saturates to DATA_W, writes the logit, and tracks a running argmax. A done
// pulse presents the predicted class and its logit.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; abandons any run in progress
//   bus    fc4_argmax_unit_if.master (handshake, read ports, logit write,
//          result)
// Timing with the start edge as edge 0: neuron k's logit is registered on edge
// 65k+64 and held on logit_data/logit_we for the following (WRITE) cycle;
// done is raised on edge 650 and sampled by the consumer on edge 651.
// -----------------------------------------------------------------------------
module fc4_argmax_unit
    import fc4_argmax_unit_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    fc4_argmax_unit_if.master bus
);

    state_t                    state_q;
    logic [IDX_W-1:0]          i_q;
    logic [CLASS_W-1:0]        neuron_q;
    logic [ADDR_W-1:0]         w_addr_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      logit_we_q;
    logic [ADDR_W-1:0]         logit_addr_q;
    logic signed [DATA_W-1:0]  logit_data_q;
    logic [CLASS_W-1:0]        pred_class_q;
    logic signed [DATA_W-1:0]  max_logit_q;
    logic signed [DATA_W-1:0]  run_max_q;
    logic [CLASS_W-1:0]        run_idx_q;

    logic                      last_i;
    logic                      last_neuron;
    logic                      mac_clr;
    logic                      mac_en;
    logic                      max_upd;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   sum_d;
    logic signed [DATA_W-1:0]  logit_d;

    assign last_i      = (i_q == IDX_W'(NUM_IN - 1));
    assign last_neuron = (neuron_q == CLASS_W'(NUM_OUT - 1));

    // Clear on the start edge and on each neuron's final MAC edge; the final
    // sum is taken from acc_nxt in that same cycle, so the clear loses nothing.
    assign mac_clr = ((state_q == ST_IDLE) && bus.start) ||
                     ((state_q == ST_MAC) && last_i);
    assign mac_en  = (state_q == ST_MAC);

    fc_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (mac_clr),
        .en_i      (mac_en),
        .a_i       (bus.act_data),
        .b_i       (bus.w_data),
        .acc_nxt_o (acc_nxt)
    );

    // Bias address is held at the current neuron for its whole MAC run, so
    // b_data is already stable when the logit is captured on the last MAC
    // edge and the logit write outputs can be fully registered.
    assign bias_ext = {{(ACC_W-DATA_W){bus.b_data[DATA_W-1]}}, bus.b_data};
    assign sum_d    = (acc_nxt >>> FRAC_BITS) + bias_ext;
    assign logit_d  = sat_data(sum_d);

    // Strict compare keeps the lower index on ties; neuron 0 always seeds.
    assign max_upd  = (neuron_q == '0) || (logit_d > run_max_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            neuron_q     <= '0;
            w_addr_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            logit_we_q   <= 1'b0;
            logit_addr_q <= '0;
            logit_data_q <= '0;
            pred_class_q <= '0;
            max_logit_q  <= DATA_MIN;
            run_max_q    <= DATA_MIN;
            run_idx_q    <= '0;
        end else begin
            done_q     <= 1'b0;
            logit_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q   <= ST_MAC;
                        busy_q    <= 1'b1;
                        i_q       <= '0;
                        neuron_q  <= '0;
                        w_addr_q  <= '0;
                        run_max_q <= DATA_MIN;
                        run_idx_q <= '0;
                    end
                end
                ST_MAC: begin
                    if (last_i) begin
                        state_q      <= ST_WRITE;
                        logit_we_q   <= 1'b1;
                        logit_addr_q <= {{(ADDR_W-CLASS_W){1'b0}}, neuron_q};
                        logit_data_q <= logit_d;
                        if (max_upd) begin
                            run_max_q <= logit_d;
                            run_idx_q <= neuron_q;
                        end
                    end else begin
                        i_q      <= i_q + IDX_W'(1);
                        w_addr_q <= w_addr_q + ADDR_W'(1);
                    end
                end
                ST_WRITE: begin
                    i_q <= '0;
                    if (last_neuron) begin
                        state_q      <= ST_DONE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        pred_class_q <= run_idx_q;
                        max_logit_q  <= run_max_q;
                        neuron_q     <= '0;
                        w_addr_q     <= '0;
                    end else begin
                        state_q  <= ST_MAC;
                        neuron_q <= neuron_q + CLASS_W'(1);
                        // Weights are laid out neuron-major, so the next
                        // neuron's first weight directly follows.
                        w_addr_q <= w_addr_q + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.act_addr   = {{(ADDR_W-IDX_W){1'b0}}, i_q};
    assign bus.w_addr     = w_addr_q;
    assign bus.b_addr     = {{(ADDR_W-CLASS_W){1'b0}}, neuron_q};
    assign bus.logit_we   = logit_we_q;
    assign bus.logit_addr = logit_addr_q;
    assign bus.logit_data = logit_data_q;
    assign bus.pred_class = pred_class_q;
    assign bus.max_logit  = max_logit_q;

endmodule

// File: tb/tb_fc4_argmax_unit.sv
module tb_fc4_argmax_unit;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    fc4_argmax_unit_if bus();

    fc4_argmax_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories seen by the unit, combinational reads.
    logic [31:0] act_mem [64];
    logic [31:0] w_mem   [640];
    logic [31:0] b_mem   [10];
    logic [31:0] exp_vec [10];

    always_comb begin
        bus.act_data = '0;
        bus.w_data   = '0;
        bus.b_data   = '0;
        if (bus.act_addr < 16'd64)  bus.act_data = act_mem[bus.act_addr[5:0]];
        if (bus.w_addr   < 16'd640) bus.w_data   = w_mem[bus.w_addr[9:0]];
        if (bus.b_addr   < 16'd10)  bus.b_data   = b_mem[bus.b_addr[3:0]];
    end

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } logit_t;

    typedef struct {
        logic [3:0]  cls;
        logic [31:0] mx;
        int          start_edge;
    } res_t;

    logit_t exp_logit_q[$];
    res_t   exp_res_q[$];

    int tests = 0;
    int fails = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int we_cnt = 0;
    int start_edge = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_logit_q.delete();
            exp_res_q.delete();
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.logit_we) begin
                we_cnt++;
                if (exp_logit_q.size() == 0) begin
                    check("unexpected logit_we", {48'd0, bus.logit_addr}, 64'hFFFF);
                end else begin
                    logit_t e;
                    e = exp_logit_q.pop_front();
                    check($sformatf("logit_addr n%0d", e.addr), {48'd0, bus.logit_addr}, {48'd0, e.addr});
                    check($sformatf("logit_data n%0d", e.addr), {32'd0, bus.logit_data}, {32'd0, e.data});
                end
            end
            if (bus.done) begin
                done_cnt++;
                if (exp_res_q.size() == 0) begin
                    check("unexpected done", 64'd1, 64'd0);
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    check("pred_class", {60'd0, bus.pred_class}, {60'd0, r.cls});
                    check("max_logit", {32'd0, bus.max_logit}, {32'd0, r.mx});
                    check("done latency", 64'(cyc + 1 - r.start_edge), 64'd651);
                    check("busy cycles", 64'(busy_cnt), 64'd650);
                    check("logits before done", 64'(exp_logit_q.size()), 64'd0);
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, " busy"},       {63'd0, bus.busy}, 64'd0);
        check({tag, " done"},       {63'd0, bus.done}, 64'd0);
        check({tag, " logit_we"},   {63'd0, bus.logit_we}, 64'd0);
        check({tag, " act_addr"},   {48'd0, bus.act_addr}, 64'd0);
        check({tag, " w_addr"},     {48'd0, bus.w_addr}, 64'd0);
        check({tag, " b_addr"},     {48'd0, bus.b_addr}, 64'd0);
        check({tag, " logit_addr"}, {48'd0, bus.logit_addr}, 64'd0);
        check({tag, " logit_data"}, {32'd0, bus.logit_data}, 64'd0);
        check({tag, " pred_class"}, {60'd0, bus.pred_class}, 64'd0);
        check({tag, " max_logit"},  {32'd0, bus.max_logit}, 64'h8000_0000);
    endtask

    // Queue the expectations in exp_vec plus the result, then pulse start.
    task automatic run_vector(input logic [3:0] cls, input logic [31:0] mx);
        res_t r;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            logit_t e;
            e.addr = 16'(k);
            e.data = exp_vec[k];
            exp_logit_q.push_back(e);
        end
        start_edge   = cyc + 1;
        r.cls        = cls;
        r.mx         = mx;
        r.start_edge = start_edge;
        exp_res_q.push_back(r);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_res_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_res_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s: done not seen within %0d cycles", name, n);
            exp_res_q.delete();
            exp_logit_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 64; i++) act_mem[i] = 32'h0001_0000;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 64; i++) w_mem[k*64 + i] = 32'(k) * 32'h0000_0400;
            b_mem[k]   = 32'd0;
            exp_vec[k] = 32'(k) << 16;
        end
    endtask

    task automatic load_negative();
        for (int i = 0; i < 64; i++) act_mem[i] = 32'h0001_0000;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 64; i++) w_mem[k*64 + i] = 32'hFFFF_0000;
            b_mem[k]   = 32'(-(k * 65536));
            exp_vec[k] = 32'(-((64 + k) * 65536));
        end
    endtask

    initial begin
        int snap_done;
        int snap_we;
        logic [31:0] bias_tab [10];

        rst_n     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 64; i++)  act_mem[i] = '0;
        for (int i = 0; i < 640; i++) w_mem[i] = '0;
        for (int k = 0; k < 10; k++)  b_mem[k] = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ramp weights: logit k = k.0, argmax 9.
        load_ramp();
        run_vector(4'd9, 32'h0009_0000);
        wait_done("ramp");

        // Zero activations: logits equal biases, tie 2/3 keeps 2.
        bias_tab = '{32'h5_0000, 32'h3_0000, 32'h9_0000, 32'h9_0000, 32'h1_0000,
                     32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 64; i++) act_mem[i] = '0;
        for (int k = 0; k < 10; k++) begin
            b_mem[k]   = bias_tab[k];
            exp_vec[k] = bias_tab[k];
        end
        run_vector(4'd2, 32'h0009_0000);
        wait_done("bias tie");

        // Positive saturation.
        for (int i = 0; i < 64; i++)  act_mem[i] = 32'h7FFF_0000;
        for (int i = 0; i < 640; i++) w_mem[i] = 32'h7FFF_0000;
        for (int k = 0; k < 10; k++) begin
            b_mem[k]   = '0;
            exp_vec[k] = 32'h7FFF_FFFF;
        end
        run_vector(4'd0, 32'h7FFF_FFFF);
        wait_done("sat pos");

        // Negative saturation.
        for (int i = 0; i < 640; i++) w_mem[i] = 32'h8001_0000;
        for (int k = 0; k < 10; k++) exp_vec[k] = 32'h8000_0000;
        run_vector(4'd0, 32'h8000_0000);
        wait_done("sat neg");

        // Negative logits -(64+k).0, argmax 0.
        load_negative();
        run_vector(4'd0, 32'hFFC0_0000);
        wait_done("negative");

        // Extra start pulses at run cycles 5, 100 and 650 are ignored.
        load_ramp();
        snap_done = done_cnt;
        snap_we   = we_cnt;
        run_vector(4'd9, 32'h0009_0000);
        for (int n = 0; n < 760; n++) begin
            @(negedge clk);
            bus.start = ((cyc - start_edge) == 5) || ((cyc - start_edge) == 100) ||
                        ((cyc - start_edge) == 650);
        end
        bus.start = 1'b0;
        check("restart done count", 64'(done_cnt - snap_done), 64'd1);
        check("restart logit count", 64'(we_cnt - snap_we), 64'd10);
        check("restart busy idle", {63'd0, bus.busy}, 64'd0);

        // Asynchronous reset at run cycle 300 abandons the run.
        load_negative();
        run_vector(4'd0, 32'hFFC0_0000);
        while ((cyc - start_edge) < 300) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset("midrun reset");
        snap_done = done_cnt;
        snap_we   = we_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post-reset logit_we", 64'(we_cnt - snap_we), 64'd0);
        check("post-reset done", 64'(done_cnt - snap_done), 64'd0);

        // Fresh run after the abandoned one is complete and correct.
        load_ramp();
        run_vector(4'd9, 32'h0009_0000);
        wait_done("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
